half_adder: RTL and testbench
=============================

// Module: half_adder
//
// PURPOSE
//   Registered, bitwise WIDTH-lane half adder used as a building block of the ALU.
//   Each bit lane i computes sum[i] = a[i] ^ b[i] and carry[i] = a[i] & b[i].
//   The adder does not ripple carries and does not shift them.
//   Results are registered on one clock with a valid strobe, so adder stages can chain.
//   Downstream logic (full adders, carry-lookahead) consumes carry as a per-lane generate vector.
//
// PARAMETERS
//   WIDTH  32  operand/result width in bits (legal: >=1)
//
// PORTS
//   clk        input   1      rising-edge clock, sole clock domain
//   rst        input   1      synchronous reset, active-high
//   in_valid   input   1      a/b hold a new operand pair this cycle
//   a          input   WIDTH  operand A, unsigned
//   b          input   WIDTH  operand B, unsigned
//   out_valid  output  1      sum/carry hold a fresh result this cycle
//   sum        output  WIDTH  per-lane XOR of the captured a and b
//   carry      output  WIDTH  per-lane AND of the captured a and b (lane i, unshifted)
//
// BEHAVIOUR
//   - All outputs are registers; there is no combinational path from inputs to outputs.
//   - Reset (rst=1 at a clk edge): sum=0, carry=0, out_valid=0. Reset has priority over in_valid.
//   - Latency 1 cycle: when in_valid=1 at edge N, then from edge N:
//       * sum   = a ^ b
//       * carry = a & b
//       * out_valid = 1
//   - in_valid=0 at an edge: out_valid<=0; sum/carry hold their last values (no X, no clear).
//   - Throughput: one operation per cycle. Back-to-back in_valid gives one result per cycle.
//   - No backpressure; the consumer must sample whenever out_valid=1.
//   - Width rules:
//       * no carry-out beyond bit WIDTH-1 and no overflow flag
//       * the arithmetic sum a+b equals sum + (carry << 1), truncated to WIDTH+1 bits
//   - Invariant: (sum & carry) == 0 on every cycle.
//   - Reset mid-operation: any result in flight is discarded; out_valid is 0 on the cycle after reset.
//   - Inputs are don't-care while in_valid=0 or rst=1.
//
// TESTING
//   1. rst=1 for 2 cycles, then idle -> sum=0, carry=0, out_valid=0.
//   2. a=5, b=3, in_valid=1 -> next cycle sum=6, carry=1, out_valid=1.
//   3. a=0xFFFFFFFF, b=0xFFFFFFFF -> sum=0x00000000, carry=0xFFFFFFFF.
//   4. a=0xAAAAAAAA, b=0x55555555 -> sum=0xFFFFFFFF, carry=0.
//      Then a=0, b=0 -> sum=0, carry=0.
//   5. Back-to-back pairs (1,1), (2,3), (0x80000000,0x80000000):
//        * results on 3 consecutive cycles: (0,1), (1,2), (0,0x80000000)
//        * then in_valid=0 -> out_valid=0, values held.
//   6. in_valid=1 and rst=1 at the same edge -> outputs 0, out_valid=0.
//      Randomized: sum+(carry<<1) == a+b, and (sum&carry)==0.

Source files
------------

// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
// Module      : half_adder
// Description : Registered WIDTH-lane bitwise half adder (per-lane XOR sum and
//               AND carry). Carries are not rippled or shifted. Results carry
//               a one-cycle valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module half_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_carry;
    logic             r_valid;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_lane
            assign w_sum[i]   = a[i] ^ b[i];
            assign w_carry[i] = a[i] & b[i];
        end
    endgenerate

    // sum/carry hold their last result while idle; only the strobe drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_carry <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum   <= w_sum;
                r_carry <= w_carry;
            end
        end
    end

    assign out_valid = r_valid;
    assign sum       = r_sum;
    assign carry     = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_half_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_half_adder
// Description : Self-checking bench for half_adder: lane-arithmetic reference
//               model, directed literal cases and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_half_adder;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] sum;
    logic [W-1:0] carry;

    int tests;
    int fails;

    logic         m_valid;
    logic [W-1:0] m_sum;
    logic [W-1:0] m_carry;
    logic         cmp_en;

    half_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .sum      (sum),
        .carry    (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: each lane adds two one-bit numbers; low digit is sum, high digit carry.
    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b0;
            m_sum   = '0;
            m_carry = '0;
        end else if (in_valid) begin
            m_valid = 1'b1;
            for (int i = 0; i < W; i++) begin
                int t;
                t = int'(a[i]) + int'(b[i]);
                m_sum[i]   = ((t % 2) == 1);
                m_carry[i] = ((t / 2) == 1);
            end
        end else begin
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, m_valid});
            chk("model_sum",   {1'b0, sum},   {1'b0, m_sum});
            chk("model_carry", {1'b0, carry}, {1'b0, m_carry});
            chk("disjoint",    {1'b0, sum & carry}, '0);
        end
    end

    task automatic step(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vv);
        a        = va;
        b        = vb;
        in_valid = vv;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input string name, input logic ev,
                              input logic [W-1:0] es, input logic [W-1:0] ec);
        chk({name, "_valid"}, {{W{1'b0}}, out_valid}, {{W{1'b0}}, ev});
        chk({name, "_sum"},   {1'b0, sum},   {1'b0, es});
        chk({name, "_carry"}, {1'b0, carry}, {1'b0, ec});
    endtask

    initial begin
        logic [W:0] arith;
        tests    = 0;
        fails    = 0;
        cmp_en   = 1'b0;
        m_valid  = 1'b0;
        m_sum    = '0;
        m_carry  = '0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;

        step('0, '0, 1'b0);
        cmp_en = 1'b1;
        step('0, '0, 1'b0);
        rst = 1'b0;
        step('0, '0, 1'b0);
        expect_lit("reset", 1'b0, 32'h0, 32'h0);

        step(32'd5, 32'd3, 1'b1);
        expect_lit("five_three", 1'b1, 32'h6, 32'h1);

        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        expect_lit("all_ones", 1'b1, 32'h0, 32'hFFFF_FFFF);

        step(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        expect_lit("alternating", 1'b1, 32'hFFFF_FFFF, 32'h0);
        step(32'h0, 32'h0, 1'b1);
        expect_lit("zeros", 1'b1, 32'h0, 32'h0);

        step(32'h1, 32'h1, 1'b1);
        expect_lit("b2b_0", 1'b1, 32'h0, 32'h1);
        step(32'h2, 32'h3, 1'b1);
        expect_lit("b2b_1", 1'b1, 32'h1, 32'h2);
        step(32'h8000_0000, 32'h8000_0000, 1'b1);
        expect_lit("b2b_2", 1'b1, 32'h0, 32'h8000_0000);
        step(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        expect_lit("idle_hold", 1'b0, 32'h0, 32'h8000_0000);

        rst = 1'b1;
        step(32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b1);
        expect_lit("rst_priority", 1'b0, 32'h0, 32'h0);
        rst = 1'b0;

        for (int n = 0; n < 300; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rv;
            logic         rr;
            ra = $urandom;
            rb = $urandom;
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 49) == 0);
            rst = rr;
            step(ra, rb, rv);
            if (!rr && rv) begin
                arith = {1'b0, sum} + {carry, 1'b0};
                chk("rand_arith", arith, {1'b0, ra} + {1'b0, rb});
            end
        end
        rst = 1'b0;
        step('0, '0, 1'b0);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
